// File: rtl/fmps_pkg.sv
// Shared constants for the FMPS read-link sequencer: status codes and the
// default index width of the DPRAM.
package fmps_pkg;

    localparam int FMPS_INDEX_WIDTH = 5;

    localparam logic [1:0] FMPS_STATUS_OK      = 2'd0;
    localparam logic [1:0] FMPS_STATUS_TIMEOUT = 2'd1;
    localparam logic [1:0] FMPS_STATUS_OVERRUN = 2'd2;
    localparam logic [1:0] FMPS_STATUS_EMPTY   = 2'd3;

endpackage

// File: rtl/fmps_readout_sequencer.sv
// Per-FA-cycle readout of the FMPS read-link DPRAM: wait for packets or a
// timeout, then stream every flagged slot as one AXI-Stream packet.
module fmps_readout_sequencer
    import fmps_pkg::*;
#(
    parameter int INDEX_WIDTH   = FMPS_INDEX_WIDTH,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     sysClk,
    input  logic                     sysReset_n,
    input  logic                     enable,
    input  logic [INDEX_WIDTH:0]     expectedCount,
    input  logic [TIMEOUT_WIDTH-1:0] timeoutLimit,
    input  logic                     cycleStrobe,
    input  logic [(1<<INDEX_WIDTH)-1:0] fmpsBitmap,
    input  logic [INDEX_WIDTH:0]     fmpsCounter,
    output logic [INDEX_WIDTH-1:0]   readoutAddress,
    input  logic [31:0]              readoutFMPS,
    output logic [31:0]              M_TDATA,
    output logic                     M_TVALID,
    output logic                     M_TLAST,
    input  logic                     M_TREADY,
    output logic                     busy,
    output logic                     statusStrobe,
    output logic [1:0]               statusCode,
    output logic [7:0]               overrunCount,
    output logic [2:0]               debugState
);

    localparam int SLOTS = 1 << INDEX_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_SCAN, ST_SETTLE, ST_EMIT, ST_DONE
    } state_t;

    state_t                   state, stateNext;
    logic [TIMEOUT_WIDTH-1:0] timer;
    logic [SLOTS-1:0]         snapshot;
    logic [SLOTS-1:0]         upperBits;
    logic                     timedOut, pending, overrunSeen, beatSeen;
    logic                     countMet;

    assign countMet   = (fmpsCounter >= expectedCount) && (expectedCount != '0);
    assign upperBits  = snapshot >> readoutAddress;
    assign busy       = (state != ST_IDLE);
    assign debugState = state;

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) state <= ST_IDLE;
        else             state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (enable && (cycleStrobe || pending)) stateNext = ST_WAIT;
            ST_WAIT:   if (countMet || (timer == timeoutLimit)) stateNext = ST_SCAN;
            ST_SCAN: begin
                if (snapshot[readoutAddress]) stateNext = ST_SETTLE;
                else if (&readoutAddress)     stateNext = ST_DONE;
            end
            ST_SETTLE: stateNext = ST_EMIT;
            ST_EMIT:   if (M_TREADY) stateNext = M_TLAST ? ST_DONE : ST_SCAN;
            ST_DONE:   stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

    // Stream handshake: M_TDATA/M_TLAST/M_TVALID are registered and held
    // unchanged until a cycle with M_TVALID && M_TREADY; the beat transfers
    // on that clock edge and M_TVALID drops on the same edge.
    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            readoutAddress <= '0;
            M_TDATA        <= '0;
            M_TVALID       <= 1'b0;
            M_TLAST        <= 1'b0;
            statusStrobe   <= 1'b0;
            statusCode     <= FMPS_STATUS_OK;
            overrunCount   <= '0;
            timer          <= '0;
            snapshot       <= '0;
            timedOut       <= 1'b0;
            pending        <= 1'b0;
            overrunSeen    <= 1'b0;
            beatSeen       <= 1'b0;
        end else begin
            statusStrobe <= 1'b0;
            if (cycleStrobe && (state != ST_IDLE)) begin
                pending     <= 1'b1;
                overrunSeen <= 1'b1;
                if (overrunCount != 8'hFF) overrunCount <= overrunCount + 8'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (stateNext == ST_WAIT) begin
                        timer       <= '0;
                        timedOut    <= 1'b0;
                        pending     <= 1'b0;
                        overrunSeen <= 1'b0;
                        beatSeen    <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + TIMEOUT_WIDTH'(1);
                    if (stateNext == ST_SCAN) begin
                        snapshot       <= fmpsBitmap;
                        readoutAddress <= '0;
                        timedOut       <= !countMet;
                    end
                end
                ST_SCAN: begin
                    if (!snapshot[readoutAddress] && !(&readoutAddress))
                        readoutAddress <= readoutAddress + INDEX_WIDTH'(1);
                end
                ST_SETTLE: begin
                    // DPRAM data for the address presented in ST_SCAN is valid now.
                    M_TDATA  <= readoutFMPS;
                    M_TVALID <= 1'b1;
                    M_TLAST  <= (upperBits[SLOTS-1:1] == '0);
                    beatSeen <= 1'b1;
                end
                ST_EMIT: begin
                    if (M_TREADY) begin
                        M_TVALID <= 1'b0;
                        if (!M_TLAST) readoutAddress <= readoutAddress + INDEX_WIDTH'(1);
                    end
                end
                ST_DONE: begin
                    statusStrobe <= 1'b1;
                    if (overrunSeen || cycleStrobe) statusCode <= FMPS_STATUS_OVERRUN;
                    else if (timedOut)              statusCode <= FMPS_STATUS_TIMEOUT;
                    else if (!beatSeen)             statusCode <= FMPS_STATUS_EMPTY;
                    else                            statusCode <= FMPS_STATUS_OK;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Bench for fmps_readout_sequencer: a DPRAM model, a packet/status
// scoreboard checked every cycle, and directed readout scenarios.
module tb_fmps_readout_sequencer;

    logic        sysClk = 1'b0;
    logic        sysReset_n = 1'b0;
    logic        enable = 1'b0;
    logic [5:0]  expectedCount = '0;
    logic [15:0] timeoutLimit = '0;
    logic        cycleStrobe = 1'b0;
    logic [31:0] fmpsBitmap = '0;
    logic [5:0]  fmpsCounter = '0;
    logic [4:0]  readoutAddress;
    logic [31:0] readoutFMPS = '0;
    logic [31:0] M_TDATA;
    logic        M_TVALID, M_TLAST;
    logic        M_TREADY = 1'b0;
    logic        busy, statusStrobe;
    logic [1:0]  statusCode;
    logic [7:0]  overrunCount;
    logic [2:0]  debugState;

    fmps_readout_sequencer #(.INDEX_WIDTH(5), .TIMEOUT_WIDTH(16)) dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .enable(enable),
        .expectedCount(expectedCount), .timeoutLimit(timeoutLimit),
        .cycleStrobe(cycleStrobe), .fmpsBitmap(fmpsBitmap), .fmpsCounter(fmpsCounter),
        .readoutAddress(readoutAddress), .readoutFMPS(readoutFMPS),
        .M_TDATA(M_TDATA), .M_TVALID(M_TVALID), .M_TLAST(M_TLAST), .M_TREADY(M_TREADY),
        .busy(busy), .statusStrobe(statusStrobe), .statusCode(statusCode),
        .overrunCount(overrunCount), .debugState(debugState)
    );

    // clock / DPRAM model / sink
    always #5 sysClk = ~sysClk;

    logic [31:0] mem [32];
    always @(posedge sysClk) readoutFMPS <= mem[readoutAddress];

    int readyMode = 1;  // 0 stall, 1 always ready, 2 random 50%
    always @(posedge sysClk) begin
        #1;
        case (readyMode)
            0:       M_TREADY = 1'b0;
            1:       M_TREADY = 1'b1;
            default: M_TREADY = 1'($urandom_range(0, 1));
        endcase
    end

    // scoreboard
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [1:0]  st_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected packet: every flagged slot in ascending order, last on the highest.
    task automatic expect_readout(input logic [31:0] bm, input bit timedOutExp, input bit overrunExp);
        int top = -1;
        for (int i = 0; i < 32; i++) if (bm[i]) top = i;
        for (int i = 0; i < 32; i++)
            if (bm[i]) exp_q.push_back({(i == top), mem[i]});
        if (overrunExp)       st_q.push_back(2'd2);
        else if (timedOutExp) st_q.push_back(2'd1);
        else if (bm == '0)    st_q.push_back(2'd3);
        else                  st_q.push_back(2'd0);
    endtask

    int          cycle = 0;
    int          strobeCount = 0;
    int          strobeInCycle = 0;
    int          firstValidDelay = -1;
    int          statusDelay = -1;
    bit          armFirst = 0;
    bit          holdPrev = 0;
    logic [31:0] prevData;
    logic        prevLast;
    logic [32:0] expBeat;
    logic [1:0]  expSt;
    logic [31:0] lastAccData = '0;
    int          nAcc = 0;
    int          acceptCycle [64];

    always @(negedge sysClk) begin
        if (!sysReset_n) begin
            holdPrev = 0;
            armFirst = 0;
        end else begin
            cycle++;
            if (cycleStrobe) begin
                strobeInCycle = cycle;
                armFirst = 1;
            end
            if (holdPrev) begin
                check("hold_valid", 64'(M_TVALID), 64'(1'b1));
                check("hold_data", 64'(M_TDATA), 64'(prevData));
                check("hold_last", 64'(M_TLAST), 64'(prevLast));
            end
            if (M_TVALID && armFirst) begin
                firstValidDelay = cycle - strobeInCycle;
                armFirst = 0;
            end
            if (M_TVALID && M_TREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat data=0x%0h expected=none at %0t", M_TDATA, $time);
                end else begin
                    expBeat = exp_q.pop_front();
                    check("beat_data", 64'(M_TDATA), 64'(expBeat[31:0]));
                    check("beat_last", 64'(M_TLAST), 64'(expBeat[32]));
                end
                lastAccData = M_TDATA;
                if (nAcc < 64) acceptCycle[nAcc] = cycle;
                nAcc++;
            end
            holdPrev = M_TVALID && !M_TREADY;
            prevData = M_TDATA;
            prevLast = M_TLAST;
            if (statusStrobe) begin
                statusDelay = cycle - strobeInCycle;
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_status code=%0d expected=none at %0t", statusCode, $time);
                end else begin
                    expSt = st_q.pop_front();
                    check("status_code", 64'(statusCode), 64'(expSt));
                end
                strobeCount++;
            end
        end
    end

    // driver tasks
    task automatic start_cycle();
        @(posedge sysClk); #1 cycleStrobe = 1'b1;
        @(posedge sysClk); #1 cycleStrobe = 1'b0;
    endtask

    task automatic setup(input logic [31:0] bm, input int cnt, input int expc, input int tmo);
        @(posedge sysClk); #1;
        fmpsBitmap    = bm;
        fmpsCounter   = 6'(cnt);
        expectedCount = 6'(expc);
        timeoutLimit  = 16'(tmo);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        int n = 0;
        while (strobeCount < target && n < budget) begin
            @(posedge sysClk);
            n++;
        end
        if (strobeCount < target) begin
            checks++;
            errors++;
            $display("FAIL wait_status strobes=%0d required=%0d", strobeCount, target);
        end
        repeat (2) @(posedge sysClk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!M_TVALID && n < budget) begin
            @(negedge sysClk);
            n++;
        end
        check("wait_valid", 64'(M_TVALID), 64'(1'b1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},    64'(readoutAddress), 64'(0));
        check({tag, "_tdata"},   64'(M_TDATA), 64'(0));
        check({tag, "_tvalid"},  64'(M_TVALID), 64'(0));
        check({tag, "_tlast"},   64'(M_TLAST), 64'(0));
        check({tag, "_busy"},    64'(busy), 64'(0));
        check({tag, "_sstrobe"}, 64'(statusStrobe), 64'(0));
        check({tag, "_scode"},   64'(statusCode), 64'(0));
        check({tag, "_ovr"},     64'(overrunCount), 64'(0));
        check({tag, "_state"},   64'(debugState), 64'(0));
    endtask

    int target = 0;
    int badGaps;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hF000_0000 + 32'(i) * 32'h0001_0001;

        // reset
        repeat (3) @(posedge sysClk);
        @(negedge sysClk);
        check_reset_values("reset");
        @(posedge sysClk); #1 sysReset_n = 1'b1;
        enable = 1'b1;

        // 12 contiguous packets, count satisfied immediately
        setup(32'h0000_0FFF, 12, 12, 1000);
        expect_readout(32'h0000_0FFF, 0, 0);
        nAcc = 0;
        start_cycle();
        target++;
        wait_strobes(target, 300);
        check("t1_first_valid_delay", 64'(firstValidDelay), 64'(4));
        check("t1_beats", 64'(nAcc), 64'(12));
        check("t1_last_data", 64'(lastAccData), 64'(32'hF00B_000B));
        check("t1_status", 64'(statusCode), 64'(0));
        badGaps = 0;
        for (int k = 0; k < 11; k++)
            if (acceptCycle[k+1] - acceptCycle[k] != 3) badGaps++;
        check("t1_beat_spacing", 64'(badGaps), 64'(0));

        // only 5 of 12 packets: timeout after 100 cycles
        setup(32'h0010_8421, 5, 12, 100);
        expect_readout(32'h0010_8421, 1, 0);
        nAcc = 0;
        start_cycle();
        target++;
        wait_strobes(target, 500);
        check("t2_first_valid_delay", 64'(firstValidDelay), 64'(104));
        check("t2_beats", 64'(nAcc), 64'(5));
        check("t2_status", 64'(statusCode), 64'(1));

        // empty bitmap with count satisfied: EMPTY, no beats
        setup(32'h0, 12, 12, 1000);
        expect_readout(32'h0, 0, 0);
        nAcc = 0;
        start_cycle();
        target++;
        wait_strobes(target, 200);
        check("t3_beats", 64'(nAcc), 64'(0));
        check("t3_status", 64'(statusCode), 64'(3));

        // empty bitmap, timeoutLimit=0: TIMEOUT outranks EMPTY, full 32-slot scan
        setup(32'h0, 0, 5, 0);
        expect_readout(32'h0, 1, 0);
        nAcc = 0;
        start_cycle();
        target++;
        wait_strobes(target, 200);
        check("t3b_beats", 64'(nAcc), 64'(0));
        check("t3b_status_delay", 64'(statusDelay), 64'(35));

        // random backpressure
        setup(32'hA5A5_0F0F, 20, 16, 1000);
        expect_readout(32'hA5A5_0F0F, 0, 0);
        readyMode = 2;
        start_cycle();
        target++;
        wait_strobes(target, 2000);
        readyMode = 1;

        // overrun: second strobe while a beat is stalled
        setup(32'h0000_00F0, 4, 4, 1000);
        expect_readout(32'h0000_00F0, 0, 1);
        expect_readout(32'h0000_00F0, 0, 0);
        readyMode = 0;
        start_cycle();
        wait_valid(50);
        start_cycle();
        readyMode = 1;
        target += 2;
        wait_strobes(target, 500);
        check("t5_overrun_count", 64'(overrunCount), 64'(1));
        check("t5_status_after_restart", 64'(statusCode), 64'(0));

        // reset during a stalled beat
        setup(32'h0000_0003, 2, 2, 1000);
        readyMode = 0;
        start_cycle();
        wait_valid(50);
        @(posedge sysClk); #3 sysReset_n = 1'b0;
        #1 check("reset_drops_valid", 64'(M_TVALID), 64'(0));
        exp_q.delete();
        st_q.delete();
        readyMode = 1;
        repeat (2) @(posedge sysClk);
        #1 sysReset_n = 1'b1;
        @(negedge sysClk);
        check_reset_values("post_reset");

        // recovery readout
        setup(32'h8000_0001, 2, 2, 1000);
        expect_readout(32'h8000_0001, 0, 0);
        nAcc = 0;
        start_cycle();
        target = strobeCount + 1;
        wait_strobes(target, 300);
        check("t7_beats", 64'(nAcc), 64'(2));
        check("t7_last_data", 64'(lastAccData), 64'(32'hF01F_001F));

        check("queues_drained", 64'(exp_q.size() + st_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
